// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes and registered result/flags.
// Build option: define ALU_MUL_EN to enable the iterative shift-add multiply (f = 3'b011).
module alu_mc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   f,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         ovf
);

    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic           load_s;
    logic           accept_s;
    logic [W-1:0]   sum_s;
    logic [W-1:0]   diff_s;
    logic [W-1:0]   res_s;
    logic           ovf_add_s;
    logic           ovf_sub_s;
    logic           ovf_s;

`ifdef ALU_MUL_EN
    localparam logic [SW:0] CNT_INIT = (SW+1)'(W);
    localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);

    logic [W-1:0]   acc_r;
    logic [W-1:0]   mcand_r;
    logic [W-1:0]   mplier_r;
    logic [SW:0]    cnt_r;
    logic [W-1:0]   acc_nx_s;
    logic           is_mul_s;
    logic           mul_last_s;
    logic           mul_start_s;
    logic           mul_done_s;
`endif

    // Single-cycle function unit; SLT reuses the subtractor and its overflow.
    always_comb begin
        sum_s     = a + b;
        diff_s    = a - b;
        ovf_add_s = (a[W-1] == b[W-1]) && (sum_s[W-1] != a[W-1]);
        ovf_sub_s = (a[W-1] != b[W-1]) && (diff_s[W-1] != a[W-1]);
        res_s     = {W{1'b0}};
        ovf_s     = 1'b0;
        case (f)
            3'b000: res_s = a & b;
            3'b001: res_s = a | b;
            3'b010: begin
                res_s = sum_s;
                ovf_s = ovf_add_s;
            end
            3'b110: begin
                res_s = diff_s;
                ovf_s = ovf_sub_s;
            end
            3'b111: res_s = {{(W-1){1'b0}}, diff_s[W-1] ^ ovf_sub_s};
            3'b100: res_s = a << b[SW-1:0];
            3'b101: res_s = a >> b[SW-1:0];
            default: begin
                res_s = {W{1'b0}};
                ovf_s = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    // Multiply step helpers: conditional add of the shifted multiplicand.
    always_comb begin
        is_mul_s   = (f == 3'b011);
        mul_last_s = (cnt_r == CNT_ONE);
        if (mplier_r[0]) begin
            acc_nx_s = acc_r + mcand_r;
        end else begin
            acc_nx_s = acc_r;
        end
    end
`endif

    // Next-state and handshake decode; in_ready never looks at in_valid.
    always_comb begin
        state_nx_s = state_r;
        in_ready   = 1'b0;
        load_s     = 1'b0;
        accept_s   = 1'b0;
`ifdef ALU_MUL_EN
        mul_start_s = 1'b0;
        mul_done_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                in_ready   = 1'b1;
                state_nx_s = IDLE;
            end
            BUSY: begin
`ifdef ALU_MUL_EN
                if (mul_last_s) begin
                    state_nx_s = DONE;
                    mul_done_s = 1'b1;
                end else begin
                    state_nx_s = BUSY;
                end
`else
                state_nx_s = IDLE;
`endif
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase

        if (in_valid && in_ready) begin
            accept_s = 1'b1;
`ifdef ALU_MUL_EN
            if (is_mul_s) begin
                state_nx_s  = BUSY;
                mul_start_s = 1'b1;
            end else begin
                state_nx_s = DONE;
                load_s     = 1'b1;
            end
`else
            state_nx_s = DONE;
            load_s     = 1'b1;
`endif
        end else begin
            accept_s = 1'b0;
        end
    end

    // State register; out_valid is a registered copy of "next state is DONE".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            out_valid <= (state_nx_s == DONE);
        end
    end

    // Result and flags are written together, only when a new result is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= {W{1'b0}};
            zero   <= 1'b1;
            ovf    <= 1'b0;
        end else if (load_s && accept_s) begin
            result <= res_s;
            zero   <= (res_s == {W{1'b0}});
            ovf    <= ovf_s;
`ifdef ALU_MUL_EN
        end else if (mul_done_s) begin
            result <= acc_nx_s;
            zero   <= (acc_nx_s == {W{1'b0}});
            ovf    <= 1'b0;
`endif
        end else begin
            result <= result;
            zero   <= zero;
            ovf    <= ovf;
        end
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: one partial product per BUSY cycle, W cycles total.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {W{1'b0}};
            mcand_r  <= {W{1'b0}};
            mplier_r <= {W{1'b0}};
            cnt_r    <= {(SW+1){1'b0}};
        end else if (mul_start_s) begin
            acc_r    <= {W{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
            cnt_r    <= CNT_INIT;
        end else if (state_r == BUSY) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= {mcand_r[W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[W-1:1]};
            cnt_r    <= cnt_r - CNT_ONE;
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc against a transaction-level reference model.
module tb_alu_mc;

    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    f;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          ovf;

    alu_mc #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .f(f), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        int           acc_edge;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   cyc = 0;
    bit   last_acc;
    bit   post_rst;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: results from plain signed/unsigned arithmetic on 64-bit values.
    function automatic exp_t ref_alu(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r;
        logic [63:0] p;
        e.res = '0; e.o = 1'b0; e.lat = 0; e.acc_edge = 0;
        case (op)
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b010: begin
                r = sx + sy; e.res = r[W-1:0];
                e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'b110: begin
                r = sx - sy; e.res = r[W-1:0];
                e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'b111: e.res = (sx < sy) ? 32'd1 : 32'd0;
            3'b100: e.res = x << (y % W);
            3'b101: e.res = x >> (y % W);
            3'b011: begin
                if (MUL_EN) begin
                    p = {32'd0, x} * {32'd0, y};
                    e.res = p[W-1:0];
                    e.lat = W;
                end else begin
                    e.res = '0;
                end
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // One clock: check at the falling edge, then step to just after the rising edge.
    task automatic cycle();
        bit   mvalid;
        bit   exp_ir;
        exp_t e;
        bit   flush = 1'b0;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst) begin
            flush = 1'b1;
        end else begin
            if (post_rst) begin
                check_eq("rst_result", result, 32'd0);
                check_eq("rst_zero", zero, 1'b1);
                check_eq("rst_ovf", ovf, 1'b0);
                post_rst = 1'b0;
            end
            mvalid = (q.size() > 0) && (cyc >= q[0].acc_edge + q[0].lat);
            exp_ir = mvalid ? out_ready : (q.size() == 0);
            check_eq("out_valid", out_valid, mvalid);
            check_eq("in_ready", in_ready, exp_ir);
            if (mvalid) begin
                check_eq("result", result, q[0].res);
                check_eq("zero", zero, q[0].z);
                check_eq("ovf", ovf, q[0].o);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_ir) begin
                e = ref_alu(f, a, b);
                e.acc_edge = cyc + 1;
                q.push_back(e);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        if (flush) begin
            q.delete();
            post_rst = 1'b1;
        end
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bit got = 1'b0;
        in_valid = 1'b1; f = op; a = x; b = y;
        for (int i = 0; i < 200 && !got; i++) begin
            cycle();
            got = last_acc;
        end
        if (!got) check_eq("accept_timeout", got, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() > 0; i++) cycle();
        if (q.size() > 0) check_eq("drain_timeout", q.size(), 0);
        cycle();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 5)
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return W'($urandom % 8);
            3: return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        f = 3'b000; a = '0; b = '0; post_rst = 1'b0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        do_op(3'b010, 32'h7FFF_FFFF, 32'd1);
        drain();
        do_op(3'b110, 32'd5, 32'd5);
        do_op(3'b111, 32'hFFFF_FFFF, 32'd1);
        drain();

        out_ready = 1'b0;
        do_op(3'b010, 32'd3, 32'd4);
        repeat (5) cycle();
        out_ready = 1'b1;
        do_op(3'b001, 32'h0000_00F0, 32'h0000_000F);
        drain();

        do_op(3'b011, 32'h0001_2345, 32'h0000_0100);
        drain();

        do_op(3'b100, 32'd1, 32'h25);
        do_op(3'b101, 32'h8000_0000, 32'd31);
        drain();

        do_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        do_op(3'b010, 32'd2, 32'd2);
        drain();

        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 4) != 0;
            f = 3'($urandom);
            a = pick();
            b = pick();
            cycle();
        end
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
